// File: rtl/snake_dir_queue.sv
`default_nettype none
// ============================================================================
// Module      : snake_dir_queue
// Description : Buffered direction-command queue for the snake game. Keypad
//               direction bytes are filtered against repeats and reversals,
//               held in a small FIFO and applied to the movement key one per
//               game step. The centre key drives the turbo output.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [7:0]  INIT_KEY   = 8'h34,
  parameter int unsigned TURBO_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   word_in,
  input  logic                         word_valid,
  input  logic                         step,
  output logic [7:0]                   key,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  output logic                         turbo_button,
  output logic                         drop
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [7:0] c_MIDDLE   = 8'h35;
  localparam logic [7:0] c_DIR_LO   = 8'h31;
  localparam logic [7:0] c_DIR_HI   = 8'h39;
  localparam logic [7:0] c_OPP_BASE = 8'h6A;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_key;
  logic          r_drop;
  logic          r_turbo;

  logic [PW-1:0] w_last_ptr;
  logic [7:0]    w_tail;
  logic [7:0]    w_tail_opp;
  logic          w_is_dir;
  logic          w_is_mid;
  logic          w_legal;
  logic          w_pop;
  logic [CW-1:0] w_count_after_pop;
  logic          w_room;
  logic          w_push;
  logic          w_drop;

  // Reference direction is the newest queued entry, or the live key when empty.
  assign w_last_ptr = r_wr_ptr - PW'(1);
  assign w_tail     = (r_count != '0) ? r_mem[w_last_ptr] : r_key;
  assign w_tail_opp = c_OPP_BASE - w_tail;

  assign w_is_dir = word_valid && (word_in >= c_DIR_LO) && (word_in <= c_DIR_HI)
                    && (word_in != c_MIDDLE);
  assign w_is_mid = word_valid && (word_in == c_MIDDLE);
  assign w_legal  = w_is_dir && (word_in != w_tail) && (word_in != w_tail_opp);

  // A simultaneous pop frees a slot for this cycle's push.
  assign w_pop             = step && (r_count != '0);
  assign w_count_after_pop = r_count - CW'(w_pop);
  assign w_room            = (w_count_after_pop < CW'(DEPTH));
  assign w_push            = w_legal && w_room;
  assign w_drop            = w_legal && !w_room;

  // Queue storage; stale contents are never read because the count gates access.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= word_in;
    end
  end

  // Pointers, occupancy, current key and the drop pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_key    <= INIT_KEY;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_key    <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_after_pop + CW'(w_push);
      r_drop  <= w_drop;
    end
  end

  generate
    if (TURBO_MODE == 0) begin : g_turbo_pulse
      // One-cycle turbo pulse per accepted MIDDLE byte.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_turbo <= 1'b0;
        end else begin
          r_turbo <= w_is_mid;
        end
      end
    end else begin : g_turbo_toggle
      // Each accepted MIDDLE byte flips the turbo level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_turbo <= 1'b0;
        end else if (w_is_mid) begin
          r_turbo <= !r_turbo;
        end
      end
    end
  endgenerate

  assign key          = r_key;
  assign queue_count  = r_count;
  assign turbo_button = r_turbo;
  assign drop         = r_drop;

endmodule
`default_nettype wire

// File: doc/snake_dir_queue.md
# snake_dir_queue

Buffered direction-command queue for the snake game, and the parametrised successor of the single-latch keyboard direction driver. It sits between the keypad/UART byte decoder and the snake movement logic. Valid direction bytes are filtered against reversal and buffered in a FIFO of depth `DEPTH`, then applied one per game step, so several fast turns between two ticks are not lost. The centre key drives the turbo output in a selectable mode.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `INIT_KEY`, 8'h34: direction loaded into `key` at reset (LEFT).
- `TURBO_MODE`, 0: 0 = `turbo_button` pulses one cycle per accepted MIDDLE byte; 1 = each accepted MIDDLE byte toggles `turbo_button`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `word_in`  in  8  ASCII keypad byte: '1'..'9' = 8'h31..8'h39.
- `word_valid`  in  1  one-cycle strobe; `word_in` is sampled only when high.
- `step`  in  1  game-tick strobe; pops one queued direction into `key`.
- `key`  out  8  current movement direction.
- `queue_count`  out  $clog2(DEPTH+1)  number of queued entries.
- `turbo_button`  out  1  turbo pulse or level, per `TURBO_MODE`.
- `drop`  out  1  one-cycle pulse: a legal direction was discarded because the queue was full.

## Operation
- Direction codes: 8'h31..8'h34 and 8'h36..8'h39. MIDDLE = 8'h35. Every other byte is ignored with no side effects.
- Opposite of direction c = 8'h6A − c. The pairs are 8/2, 4/6, 7/3 and 9/1.
- Reference direction `tail` = newest queued entry if `queue_count`>0, else `key`. It is always evaluated on pre-edge state.
- A direction byte d is legal iff d != tail and d != 8'h6A − tail. Illegal bytes are silently ignored.
- `pop` = `step` && `queue_count`>0. On pop, `key` ← head entry and the head is removed.
- `step` with an empty queue: `key` is unchanged. This is not an error.
- Push of a legal d: accepted iff (`queue_count` − pop) < `DEPTH`, i.e. a simultaneous pop frees a slot. Otherwise `drop`=1 for one cycle and the queue is unchanged.
- Next count = `queue_count` − pop + push. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- No bypass: push and pop in the same cycle with an empty queue is impossible (pop=0). The pushed entry waits for the next `step`.
- MIDDLE with `word_valid`:
  - `TURBO_MODE`=0: `turbo_button`=1 for exactly the next cycle.
  - `TURBO_MODE`=1: `turbo_button` toggles.
  - The queue is never affected.

## Timing
- Reset (`rst`=0, asynchronous, any time including mid-operation): `key`=`INIT_KEY`, `queue_count`=0, pointers=0, `turbo_button`=0, `drop`=0. Queued entries are discarded.
- All outputs are registered and change only on rising `clk`.
- Latency:
  - `word_valid` → `queue_count` increment: 1 cycle.
  - `step` → new `key`: 1 cycle.
  - Byte → `drop` or turbo pulse: 1 cycle.
- `drop` and a `TURBO_MODE`=0 turbo pulse each last exactly one cycle. Back-to-back strobes produce back-to-back pulses.
- No handshake back-pressure: a byte that is not accepted is lost. `drop` is the only report of this.

## Test plan
- Reset then `step` ×3 with no input: `key` stays 8'h34, `queue_count`=0, `drop` never asserts.
- From reset, strobe 8'h36 (RIGHT, opposite of LEFT), then 8'h34 (LEFT, equal to key): `queue_count` stays 0. Then strobe 8'h38 then 8'h36: count=2. Two `step`s: `key`=8'h38, then 8'h36.
- `DEPTH`=4: strobe 8'h38, 8'h34, 8'h32, 8'h36, 8'h38: count=4, `drop` pulses once on the fifth byte. Same fifth byte strobed together with `step`: accepted, count stays 4, `key`=8'h38, no `drop`.
- Diagonals: with `key`=8'h34, strobe 8'h39 then 8'h31 (opposite of the queued 9): only 8'h39 is queued. Then 8'h33: queued. Count=2.
- MIDDLE 8'h35 ×3, non-consecutive:
  - `TURBO_MODE`=0: three single-cycle pulses.
  - `TURBO_MODE`=1: level goes 1, 0, 1.
  - In both modes `queue_count` is unchanged.
  - Byte 8'h41 is ignored.
- Assert `rst`=0 asynchronously between clock edges with count=3 and `turbo_button`=1: all outputs return to reset values immediately. After release, the first legal byte queues normally.
